// File: rtl/reset_seq_pkg.sv
// Shared types and elaboration helpers for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_HOLD,
    ST_RELEASE,
    ST_RUN
  } state_e;

  // Sized so the longest in-state count (hold or full stagger span) always fits.
  function automatic int cnt_width(input int hold_cycles, input int stagger_cycles,
                                   input int num_out);
    return $clog2(hold_cycles + stagger_cycles * num_out + 2);
  endfunction

  function automatic bit params_ok(input int num_out, input int hold_cycles,
                                   input int stagger_cycles, input int sync_stages,
                                   input int aux_min_width);
    return (num_out >= 1) && (num_out <= 8) && (hold_cycles >= 1) &&
           (stagger_cycles >= 0) && (sync_stages >= 2) && (aux_min_width >= 1);
  endfunction

endpackage

// File: rtl/rst_sync_cell.sv
// Flop chain synchroniser whose stages all reset asynchronously to RESET_VAL.
module rst_sync_cell #(
  parameter int STAGES    = 2,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its neighbour's pre-edge value; blocking here would collapse the chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= {STAGES{RESET_VAL}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/reset_seq_ctrl.sv
// Reset sequencer: filters reset sources, holds, then releases interconnect
// and staggered peripheral resets in order.
module reset_seq_ctrl
  import reset_seq_pkg::*;
#(
  parameter int NUM_OUT        = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int AUX_MIN_WIDTH  = 4
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               aux_reset_in,
  input  logic               dcm_locked,
  input  logic               sw_reset_req,
  output logic               interconnect_aresetn,
  output logic [NUM_OUT-1:0] peripheral_aresetn,
  output logic               reset_done
);

  if (!params_ok(NUM_OUT, HOLD_CYCLES, STAGGER_CYCLES, SYNC_STAGES, AUX_MIN_WIDTH)) begin : g_param_err
    $error("reset_seq_ctrl: parameter out of range");
  end

  localparam int CW = cnt_width(HOLD_CYCLES, STAGGER_CYCLES, NUM_OUT);
  localparam int AW = $clog2(AUX_MIN_WIDTH + 1);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [AW-1:0] aux_cnt_t;

  localparam cnt_t     HOLD_LAST    = cnt_t'(HOLD_CYCLES - 1);
  localparam cnt_t     LAST_STAGGER = cnt_t'(STAGGER_CYCLES * (NUM_OUT - 1));
  localparam aux_cnt_t AUX_SAT      = aux_cnt_t'(AUX_MIN_WIDTH);

  logic w_rst_n;
  logic w_aux_sync;
  logic w_dcm_sync;
  logic w_aux_active;
  logic w_src_active;

  // The internal reset asserts asynchronously with aresetn but releases only
  // after SYNC_STAGES clean edges.
  rst_sync_cell #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_rst_sync (
    .i_clk   (aclk),
    .i_rst_n (aresetn),
    .i_d     (1'b1),
    .o_q     (w_rst_n)
  );

  rst_sync_cell #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_aux_sync (
    .i_clk   (aclk),
    .i_rst_n (aresetn),
    .i_d     (aux_reset_in),
    .o_q     (w_aux_sync)
  );

  rst_sync_cell #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_dcm_sync (
    .i_clk   (aclk),
    .i_rst_n (aresetn),
    .i_d     (dcm_locked),
    .o_q     (w_dcm_sync)
  );

  aux_cnt_t r_aux_cnt;

  always_ff @(posedge aclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_aux_cnt <= '0;
    end else if (w_aux_sync) begin
      r_aux_cnt <= '0;
    end else if (r_aux_cnt != AUX_SAT) begin
      r_aux_cnt <= r_aux_cnt + aux_cnt_t'(1);
    end
  end

  state_e             r_state;
  state_e             w_state_nxt;
  cnt_t               r_cnt;
  cnt_t               w_cnt_nxt;
  logic               r_ic;
  logic               w_ic_nxt;
  logic [NUM_OUT-1:0] r_periph;
  logic [NUM_OUT-1:0] w_periph_nxt;
  logic               r_done;
  logic               w_done_nxt;

  assign w_aux_active = (r_aux_cnt == AUX_SAT);
  // A software request only matters once releases have begun.
  assign w_src_active = w_aux_active | ~w_dcm_sync |
                        (sw_reset_req & ((r_state == ST_RELEASE) | (r_state == ST_RUN)));

  // NOTE: every signal driven here gets a default first, so no path through the
  // case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_ic_nxt     = r_ic;
    w_periph_nxt = r_periph;
    w_done_nxt   = r_done;

    if (w_src_active) begin
      w_state_nxt  = ST_ASSERT;
      w_cnt_nxt    = '0;
      w_ic_nxt     = 1'b0;
      w_periph_nxt = '0;
      w_done_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        ST_ASSERT: begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
        end
        ST_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            w_state_nxt = ST_RELEASE;
            w_cnt_nxt   = '0;
            w_ic_nxt    = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + cnt_t'(1);
          end
        end
        ST_RELEASE: begin
          for (int i = 0; i < NUM_OUT; i++) begin
            if (r_cnt == cnt_t'(STAGGER_CYCLES * i)) begin
              w_periph_nxt[i] = 1'b1;
            end
          end
          if (r_cnt == LAST_STAGGER) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + cnt_t'(1);
          end
        end
        ST_RUN: begin
          w_state_nxt = ST_RUN;
        end
        default: begin
          w_state_nxt = ST_ASSERT;
        end
      endcase
    end
  end

  // NOTE: only control state is reset here; there is no memory array, so every
  // flop gets an explicit reset value and outputs are low the moment aresetn falls.
  always_ff @(posedge aclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state  <= ST_ASSERT;
      r_cnt    <= '0;
      r_ic     <= 1'b0;
      r_periph <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ic     <= w_ic_nxt;
      r_periph <= w_periph_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign interconnect_aresetn = r_ic;
  assign peripheral_aresetn   = r_periph;
  assign reset_done           = r_done;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed bench for reset_seq_ctrl: default instance plus an 8-channel,
// zero-stagger instance sharing the same stimulus.
module tb_reset_seq_ctrl;

  logic       aclk;
  logic       aresetn;
  logic       aux_reset_in;
  logic       dcm_locked;
  logic       sw_reset_req;
  logic       ic;
  logic [2:0] periph;
  logic       done;
  logic       ic8;
  logic [7:0] periph8;
  logic       done8;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = -1;

  reset_seq_ctrl u_dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .aux_reset_in         (aux_reset_in),
    .dcm_locked           (dcm_locked),
    .sw_reset_req         (sw_reset_req),
    .interconnect_aresetn (ic),
    .peripheral_aresetn   (periph),
    .reset_done           (done)
  );

  reset_seq_ctrl #(.NUM_OUT(8), .STAGGER_CYCLES(0)) u_dut8 (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .aux_reset_in         (aux_reset_in),
    .dcm_locked           (dcm_locked),
    .sw_reset_req         (sw_reset_req),
    .interconnect_aresetn (ic8),
    .peripheral_aresetn   (periph8),
    .reset_done           (done8)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) edge_n <= edge_n + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", edge_n);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic a_ic, input logic [31:0] a_p,
                            input logic a_done, input logic e_ic, input logic [31:0] e_p,
                            input logic e_done);
    check($sformatf("%s ic", tag), 32'(a_ic), 32'(e_ic));
    check($sformatf("%s periph", tag), a_p, e_p);
    check($sformatf("%s done", tag), 32'(a_done), 32'(e_done));
  endtask

  // Returns on the falling edge following rising edge n.
  task automatic wait_to(input int n);
    int guard = 0;
    while (edge_n < n && guard < 1000) begin
      @(negedge aclk);
      guard++;
    end
    if (edge_n != n) check("wait_to", 32'(edge_n), 32'(n));
  endtask

  // Expected release timeline relative to E, the edge ASSERT saw no source.
  task automatic release_seq(input int e, input bit with8);
    wait_to(e + 15); check_outs("hold_end", ic, 32'(periph), done, 1'b0, 32'h0, 1'b0);
    wait_to(e + 16); check_outs("ic_up", ic, 32'(periph), done, 1'b1, 32'h0, 1'b0);
    if (with8) check_outs("d8_ic_up", ic8, 32'(periph8), done8, 1'b1, 32'h00, 1'b0);
    wait_to(e + 17); check_outs("p0_up", ic, 32'(periph), done, 1'b1, 32'h1, 1'b0);
    if (with8) check_outs("d8_all_up", ic8, 32'(periph8), done8, 1'b1, 32'hff, 1'b1);
    wait_to(e + 20); check_outs("p1_wait", ic, 32'(periph), done, 1'b1, 32'h1, 1'b0);
    wait_to(e + 21); check_outs("p1_up", ic, 32'(periph), done, 1'b1, 32'h3, 1'b0);
    wait_to(e + 24); check_outs("p2_wait", ic, 32'(periph), done, 1'b1, 32'h3, 1'b0);
    wait_to(e + 25); check_outs("p2_up", ic, 32'(periph), done, 1'b1, 32'h7, 1'b1);
  endtask

  initial begin
    aresetn      = 1'b0;
    aux_reset_in = 1'b1;
    dcm_locked   = 1'b1;
    sw_reset_req = 1'b0;

    #2;
    check_outs("reset", ic, 32'(periph), done, 1'b0, 32'h0, 1'b0);
    check_outs("d8_reset", ic8, 32'(periph8), done8, 1'b0, 32'h00, 1'b0);

    // Power-up: aresetn rises after edge 0, so E = 3.
    wait_to(0);
    aresetn = 1'b1;
    wait_to(2);
    check_outs("sync_wait", ic, 32'(periph), done, 1'b0, 32'h0, 1'b0);
    release_seq(3, 1'b1);

    // Aux glitch of three samples (edges 31..33) is filtered out.
    wait_to(30); aux_reset_in = 1'b0;
    wait_to(33); aux_reset_in = 1'b1;
    wait_to(37); check_outs("glitch3_a", ic, 32'(periph), done, 1'b1, 32'h7, 1'b1);
    wait_to(38); check_outs("glitch3_b", ic, 32'(periph), done, 1'b1, 32'h7, 1'b1);

    // Four low samples (edges 41..44) assert reset at edge 47; E = 48.
    wait_to(40); aux_reset_in = 1'b0;
    wait_to(44); aux_reset_in = 1'b1;
    wait_to(46); check_outs("aux4_pre", ic, 32'(periph), done, 1'b1, 32'h7, 1'b1);
    wait_to(47); check_outs("aux4_low", ic, 32'(periph), done, 1'b0, 32'h0, 1'b0);
    release_seq(48, 1'b0);

    // Software request in RUN at edge 76, ignored pulse in HOLD at edge 81.
    wait_to(75); check_outs("sw_pre", ic, 32'(periph), done, 1'b1, 32'h7, 1'b1);
    sw_reset_req = 1'b1;
    wait_to(76); sw_reset_req = 1'b0;
    check_outs("sw_low", ic, 32'(periph), done, 1'b0, 32'h0, 1'b0);
    wait_to(80); sw_reset_req = 1'b1;
    wait_to(81); sw_reset_req = 1'b0;
    release_seq(77, 1'b0);

    // New sequence via sw (E = 106); dcm drop sampled at edge 125 mid-release.
    wait_to(104); sw_reset_req = 1'b1;
    wait_to(105); sw_reset_req = 1'b0;
    check_outs("sw2_low", ic, 32'(periph), done, 1'b0, 32'h0, 1'b0);
    wait_to(122); check_outs("dcm_ic_up", ic, 32'(periph), done, 1'b1, 32'h0, 1'b0);
    wait_to(123); check_outs("dcm_p0_up", ic, 32'(periph), done, 1'b1, 32'h1, 1'b0);
    wait_to(124); dcm_locked = 1'b0;
    wait_to(126); check_outs("dcm_pre", ic, 32'(periph), done, 1'b1, 32'h1, 1'b0);
    wait_to(127); check_outs("dcm_low", ic, 32'(periph), done, 1'b0, 32'h0, 1'b0);
    wait_to(130); dcm_locked = 1'b1;
    wait_to(132); check_outs("relock_wait", ic, 32'(periph), done, 1'b0, 32'h0, 1'b0);
    release_seq(133, 1'b0);

    // aresetn mid-release (E = 162, p0 up at 179) clears outputs with no edge.
    wait_to(160); sw_reset_req = 1'b1;
    wait_to(161); sw_reset_req = 1'b0;
    wait_to(179); check_outs("arst_pre", ic, 32'(periph), done, 1'b1, 32'h1, 1'b0);
    wait_to(180);
    #2 aresetn = 1'b0;
    #1;
    check_outs("arst_async", ic, 32'(periph), done, 1'b0, 32'h0, 1'b0);
    check_outs("d8_arst_async", ic8, 32'(periph8), done8, 1'b0, 32'h00, 1'b0);
    wait_to(182); aresetn = 1'b1;
    release_seq(185, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
